// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the data-bus handshake and
// produces one registered writeback record per accepted execute result.
module memory_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [3:0]      in_memop,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_rdst,
    output logic            stall,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic [4:0]      out_rdst,
    output logic [XLEN-1:0] out_result,
    output logic            out_misalign
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LHU = 4'd6;
    localparam logic [3:0] OP_LWU = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SD);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    function automatic logic [2:0] op_size(input logic [3:0] op);
        logic [2:0] size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = 3'd0;
            OP_LH, OP_LHU, OP_SH: size = 3'd1;
            OP_LW, OP_LWU, OP_SW: size = 3'd2;
            OP_LD, OP_SD:         size = 3'd3;
            default:              size = 3'd0;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (off[0] == 1'b0);
            3'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] size_strobe(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // The bus returns the whole aligned doubleword; shift the addressed bytes down to lane 0.
    function automatic logic [XLEN-1:0] load_extend(input logic [3:0] op,
                                                    input logic [XLEN-1:0] data,
                                                    input logic [2:0] off);
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] res;
        raw = data >> {off, 3'b000};
        case (op)
            OP_LB:   res = {{(XLEN-8){raw[7]}}, raw[7:0]};
            OP_LH:   res = {{(XLEN-16){raw[15]}}, raw[15:0]};
            OP_LW:   res = {{(XLEN-32){raw[31]}}, raw[31:0]};
            OP_LBU:  res = {{(XLEN-8){1'b0}}, raw[7:0]};
            OP_LHU:  res = {{(XLEN-16){1'b0}}, raw[15:0]};
            OP_LWU:  res = {{(XLEN-32){1'b0}}, raw[31:0]};
            OP_LD:   res = raw;
            default: res = raw;
        endcase
        return res;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            stall_s;
    logic            mem_s;
    logic            aligned_s;
    logic            complete_s;
    logic [2:0]      in_size_s;

    logic [3:0]      op_r;
    logic [XLEN-1:0] result_r;
    logic [4:0]      rdst_r;
    logic            dreq_valid_r;
    logic [XLEN-1:0] dreq_addr_r;
    logic [2:0]      dreq_size_r;
    logic [7:0]      dreq_strobe_r;
    logic [XLEN-1:0] dreq_data_r;
    logic            out_valid_r;
    logic [4:0]      out_rdst_r;
    logic [XLEN-1:0] out_result_r;
    logic            out_misalign_r;

    assign mem_s      = op_is_mem(in_memop);
    assign in_size_s  = op_size(in_memop);
    assign aligned_s  = is_aligned(in_size_s, in_addr[2:0]);
    assign complete_s = ((state_r == ST_REQ) && dresp_addr_ok && dresp_data_ok) ||
                        ((state_r == ST_WAIT) && dresp_data_ok);

    // Next-state and stall decode.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && mem_s && aligned_s) begin
                    state_next_s = ST_REQ;
                    stall_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                    stall_s      = 1'b0;
                end
            end
            ST_REQ: begin
                if (dresp_addr_ok && dresp_data_ok) begin
                    state_next_s = ST_IDLE;
                    stall_s      = 1'b0;
                end else if (dresp_addr_ok) begin
                    state_next_s = ST_WAIT;
                    stall_s      = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                    stall_s      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dresp_data_ok) begin
                    state_next_s = ST_IDLE;
                    stall_s      = 1'b0;
                end else begin
                    state_next_s = ST_WAIT;
                    stall_s      = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                stall_s      = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latching, bus request fields and the writeback record.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r           <= 4'd0;
            result_r       <= '0;
            rdst_r         <= 5'd0;
            dreq_valid_r   <= 1'b0;
            dreq_addr_r    <= '0;
            dreq_size_r    <= 3'd0;
            dreq_strobe_r  <= 8'h00;
            dreq_data_r    <= '0;
            out_valid_r    <= 1'b0;
            out_rdst_r     <= 5'd0;
            out_result_r   <= '0;
            out_misalign_r <= 1'b0;
        end else begin
            out_valid_r    <= 1'b0;
            out_misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && !mem_s) begin
                        out_valid_r  <= 1'b1;
                        out_result_r <= in_result;
                        out_rdst_r   <= in_rdst;
                    end else if (in_valid && !aligned_s) begin
                        out_valid_r    <= 1'b1;
                        out_misalign_r <= 1'b1;
                        out_result_r   <= '0;
                        out_rdst_r     <= 5'd0;
                    end else if (in_valid) begin
                        op_r         <= in_memop;
                        result_r     <= in_result;
                        rdst_r       <= in_rdst;
                        dreq_valid_r <= 1'b1;
                        dreq_addr_r  <= in_addr;
                        dreq_size_r  <= in_size_s;
                        if (op_is_store(in_memop)) begin
                            dreq_strobe_r <= size_strobe(in_size_s, in_addr[2:0]);
                            dreq_data_r   <= in_wdata << {in_addr[2:0], 3'b000};
                        end else begin
                            dreq_strobe_r <= 8'h00;
                            dreq_data_r   <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (dresp_addr_ok) begin
                        dreq_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    dreq_valid_r <= 1'b0;
                end
                default: begin
                    dreq_valid_r <= 1'b0;
                end
            endcase
            if (complete_s) begin
                out_valid_r <= 1'b1;
                if (op_is_store(op_r)) begin
                    out_result_r <= result_r;
                    out_rdst_r   <= 5'd0;
                end else begin
                    out_result_r <= load_extend(op_r, dresp_data, dreq_addr_r[2:0]);
                    out_rdst_r   <= rdst_r;
                end
            end
        end
    end

    // Reset forces stall low so every output reads 0 while reset is held.
    assign stall        = stall_s & ~reset;
    assign dreq_valid   = dreq_valid_r;
    assign dreq_addr    = dreq_addr_r;
    assign dreq_size    = dreq_size_r;
    assign dreq_strobe  = dreq_strobe_r;
    assign dreq_data    = dreq_data_r;
    assign out_valid    = out_valid_r;
    assign out_rdst     = out_rdst_r;
    assign out_result   = out_result_r;
    assign out_misalign = out_misalign_r;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, reset-in-flight
// sequence, and randomized ops checked against an arithmetic reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_memop;
    logic [63:0] in_addr, in_wdata, in_result;
    logic [4:0]  in_rdst;
    logic        stall, dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid, out_misalign;
    logic [4:0]  out_rdst;
    logic [63:0] out_result;

    int checks = 0;
    int errors = 0;

    memory_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_memop(in_memop),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result), .in_rdst(in_rdst),
        .stall(stall), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(out_valid),
        .out_rdst(out_rdst), .out_result(out_result), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  memop;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] result;
        logic [4:0]  rdst;
        logic [63:0] rdata;
        int          a_dly;
        int          d_dly;
        bit          same;
        bit          e_bus;
        logic [2:0]  e_size;
        logic [7:0]  e_strobe;
        logic [63:0] e_ddata;
        logic [63:0] e_result;
        logic [4:0]  e_rdst;
        bit          e_mis;
    } vec_t;

    int op_bytes [16] = '{0, 1, 2, 4, 8, 1, 2, 4, 1, 2, 4, 8, 0, 0, 0, 0};
    bit op_signed[16] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: byte count, alignment and lane positions derived arithmetically.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int nb, off;
        logic [63:0] mask, val;
        r = v;
        nb = op_bytes[v.memop];
        off = int'(v.addr % 64'd8);
        r.e_bus = 1'b0; r.e_mis = 1'b0; r.e_size = 3'd0; r.e_strobe = 8'h00; r.e_ddata = 64'd0;
        if (nb == 0) begin
            r.e_result = v.result; r.e_rdst = v.rdst;
        end else if (off % nb != 0) begin
            r.e_mis = 1'b1; r.e_result = 64'd0; r.e_rdst = 5'd0;
        end else begin
            r.e_bus = 1'b1;
            r.e_size = 3'((nb == 1) ? 0 : (nb == 2) ? 1 : (nb == 4) ? 2 : 3);
            if (v.memop >= 4'd8) begin
                r.e_strobe = 8'(((1 << nb) - 1) << off);
                r.e_ddata = v.wdata << (8 * off);
                r.e_result = v.result; r.e_rdst = 5'd0;
            end else begin
                mask = (nb == 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
                val = (v.rdata >> (8 * off)) & mask;
                if (op_signed[v.memop] && val[8 * nb - 1]) val = val | ~mask;
                r.e_result = val; r.e_rdst = v.rdst;
            end
        end
        return r;
    endfunction

    task automatic check_req(input vec_t v, input string tag);
        chk({tag, " dreq_valid"}, 64'(dreq_valid), 64'd1);
        chk({tag, " dreq_addr"}, dreq_addr, v.addr);
        chk({tag, " dreq_size"}, 64'(dreq_size), 64'(v.e_size));
        chk({tag, " dreq_strobe"}, 64'(dreq_strobe), 64'(v.e_strobe));
        if (v.memop >= 4'd8) chk({tag, " dreq_data"}, dreq_data, v.e_ddata);
    endtask

    // Drives one op starting at a falling edge and plays the bus responder.
    task automatic run_op(input vec_t v, input string tag);
        in_valid = 1'b1; in_memop = v.memop; in_addr = v.addr; in_wdata = v.wdata;
        in_result = v.result; in_rdst = v.rdst; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        #1;
        chk({tag, " accept stall"}, 64'(stall), 64'(v.e_bus));
        chk({tag, " accept dreq_valid"}, 64'(dreq_valid), 64'd0);
        step();
        if (v.e_bus) begin
            for (int i = 0; i < v.a_dly; i++) begin
                check_req(v, tag);
                chk({tag, " req stall"}, 64'(stall), 64'd1);
                chk({tag, " req out_valid"}, 64'(out_valid), 64'd0);
                step();
            end
            dresp_addr_ok = 1'b1;
            if (v.same) begin
                dresp_data_ok = 1'b1; dresp_data = v.rdata; in_valid = 1'b0;
            end
            #1;
            check_req(v, tag);
            chk({tag, " addr_ok stall"}, 64'(stall), v.same ? 64'd0 : 64'd1);
            step();
            dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
            if (!v.same) begin
                for (int i = 0; i < v.d_dly; i++) begin
                    dresp_data = {$urandom, $urandom};
                    #1;
                    chk({tag, " wait dreq_valid"}, 64'(dreq_valid), 64'd0);
                    chk({tag, " wait stall"}, 64'(stall), 64'd1);
                    step();
                end
                dresp_data_ok = 1'b1; dresp_data = v.rdata; in_valid = 1'b0;
                #1;
                chk({tag, " data_ok stall"}, 64'(stall), 64'd0);
                step();
                dresp_data_ok = 1'b0;
            end
        end else begin
            in_valid = 1'b0;
        end
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " out_result"}, out_result, v.e_result);
        chk({tag, " out_rdst"}, 64'(out_rdst), 64'(v.e_rdst));
        chk({tag, " out_misalign"}, 64'(out_misalign), 64'(v.e_mis));
        chk({tag, " done dreq_valid"}, 64'(dreq_valid), 64'd0);
        chk({tag, " done stall"}, 64'(stall), 64'd0);
        step();
        chk({tag, " pulse out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " pulse out_misalign"}, 64'(out_misalign), 64'd0);
    endtask

    vec_t vecs[14];
    vec_t v;
    int   off, nb;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_memop = 4'd0; in_addr = 64'd0; in_wdata = 64'd0;
        in_result = 64'd0; in_rdst = 5'd0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        dresp_data = 64'd0;

        //            op     addr          wdata                  result    rd     rdata                  a  d  same bus sz    strobe  ddata                  e_result               e_rd  mis
        vecs[0]  = '{4'd0,  64'h0,       64'h0,                 64'h1234, 5'd5,  64'h0,                 0, 0, 0, 0, 3'd0, 8'h00, 64'h0,                 64'h1234,              5'd5,  0};
        vecs[1]  = '{4'd1,  64'h1003,    64'h0,                 64'h0,    5'd7,  64'h00000000_80000000, 2, 2, 0, 1, 3'd0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 0};
        vecs[2]  = '{4'd6,  64'h2006,    64'h0,                 64'h0,    5'd10, 64'hBEEF_0000_0000_0000, 0, 0, 1, 1, 3'd1, 8'h00, 64'h0,                 64'h0000_0000_0000_BEEF, 5'd10, 0};
        vecs[3]  = '{4'd10, 64'h3004,    64'hDEADBEEF,          64'h55,   5'd3,  64'h0,                 1, 1, 0, 1, 3'd2, 8'hF0, 64'hDEADBEEF_00000000, 64'h55,                5'd0,  0};
        vecs[4]  = '{4'd3,  64'h4002,    64'h0,                 64'h99,   5'd4,  64'h0,                 0, 0, 0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                 5'd0,  1};
        vecs[5]  = '{4'd8,  64'h5007,    64'hAB,                64'h66,   5'd8,  64'h0,                 0, 1, 0, 1, 3'd0, 8'h80, 64'hAB00_0000_0000_0000, 64'h66,              5'd0,  0};
        vecs[6]  = '{4'd4,  64'h6000,    64'h0,                 64'h0,    5'd11, 64'h0123_4567_89AB_CDEF, 1, 0, 1, 1, 3'd3, 8'h00, 64'h0,               64'h0123_4567_89AB_CDEF, 5'd11, 0};
        vecs[7]  = '{4'd7,  64'h7004,    64'h0,                 64'h0,    5'd12, 64'h89AB_CDEF_0000_0000, 0, 1, 0, 1, 3'd2, 8'h00, 64'h0,               64'h0000_0000_89AB_CDEF, 5'd12, 0};
        vecs[8]  = '{4'd3,  64'h7004,    64'h0,                 64'h0,    5'd13, 64'h89AB_CDEF_0000_0000, 0, 0, 1, 1, 3'd2, 8'h00, 64'h0,               64'hFFFF_FFFF_89AB_CDEF, 5'd13, 0};
        vecs[9]  = '{4'd11, 64'h800C,    64'h1,                 64'h2,    5'd14, 64'h0,                 0, 0, 0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                 5'd0,  1};
        vecs[10] = '{4'd9,  64'h9001,    64'h1,                 64'h2,    5'd14, 64'h0,                 0, 0, 0, 0, 3'd0, 8'h00, 64'h0,                 64'h0,                 5'd0,  1};
        vecs[11] = '{4'd13, 64'h3,       64'h0,                 64'h77,   5'd9,  64'h0,                 0, 0, 0, 0, 3'd0, 8'h00, 64'h0,                 64'h77,                5'd9,  0};
        vecs[12] = '{4'd2,  64'hA002,    64'h0,                 64'h0,    5'd15, 64'h0000_0000_7FFF_0000, 0, 0, 0, 1, 3'd1, 8'h00, 64'h0,               64'h0000_0000_0000_7FFF, 5'd15, 0};
        vecs[13] = '{4'd11, 64'h8008,    64'hCAFEBABE_12345678, 64'h21,   5'd1,  64'h0,                 0, 0, 0, 1, 3'd3, 8'hFF, 64'hCAFEBABE_12345678, 64'h21,                5'd0,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset dreq_valid", 64'(dreq_valid), 64'd0);
        chk("reset dreq_addr", dreq_addr, 64'd0);
        chk("reset dreq_size", 64'(dreq_size), 64'd0);
        chk("reset dreq_strobe", 64'(dreq_strobe), 64'd0);
        chk("reset dreq_data", dreq_data, 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_result", out_result, 64'd0);
        chk("reset out_rdst", 64'(out_rdst), 64'd0);
        chk("reset out_misalign", 64'(out_misalign), 64'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while in WAIT, then a stray data_ok must not produce a record.
        in_valid = 1'b1; in_memop = 4'd4; in_addr = 64'h10; in_rdst = 5'd6; in_result = 64'd0;
        #1;
        chk("rst_wait accept stall", 64'(stall), 64'd1);
        step();
        dresp_addr_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        #1;
        chk("rst_wait in_wait dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_wait in_wait stall", 64'(stall), 64'd1);
        reset = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("rst_wait after dreq_valid", 64'(dreq_valid), 64'd0);
        chk("rst_wait after stall", 64'(stall), 64'd0);
        chk("rst_wait after out_valid", 64'(out_valid), 64'd0);
        step();
        dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_0000_FFFF_0000;
        #1;
        chk("rst_wait stray stall", 64'(stall), 64'd0);
        step();
        dresp_data_ok = 1'b0;
        #1;
        chk("rst_wait stray out_valid", 64'(out_valid), 64'd0);
        step();
        chk("rst_wait stray out_valid2", 64'(out_valid), 64'd0);
        chk("rst_wait stray dreq_valid", 64'(dreq_valid), 64'd0);
        run_op(vecs[0], "rst_wait next_none");

        // Randomized ops against the reference model, with stray responses in IDLE.
        for (int n = 0; n < 150; n++) begin
            v.memop = 4'($urandom_range(0, 15));
            nb = op_bytes[v.memop];
            off = int'($urandom_range(0, 7));
            if (nb > 0 && $urandom_range(0, 1) == 1) off = off - (off % nb);
            v.addr   = {32'($urandom), 29'($urandom), 3'(off)};
            v.wdata  = {$urandom, $urandom};
            v.result = {$urandom, $urandom};
            v.rdst   = 5'($urandom_range(0, 31));
            v.rdata  = {$urandom, $urandom};
            v.a_dly  = int'($urandom_range(0, 3));
            v.d_dly  = int'($urandom_range(0, 3));
            v.same   = 1'($urandom_range(0, 1));
            v = model(v);
            run_op(v, $sformatf("rand%0d op%0d", n, v.memop));
            if ($urandom_range(0, 3) == 0) begin
                dresp_addr_ok = 1'($urandom_range(0, 1));
                dresp_data_ok = 1'b1;
                #1;
                chk("stray stall", 64'(stall), 64'd0);
                step();
                dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
                #1;
                chk("stray out_valid", 64'(out_valid), 64'd0);
                chk("stray dreq_valid", 64'(dreq_valid), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of execute. It consumes execute results (ALU result/address, store data, destination register) and performs loads and stores over the data-bus handshake. It produces registered writeback data and holds the pipeline with `stall` while a bus transaction is outstanding. Load data is aligned and sign- or zero-extended here.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute result present this cycle
- in_memop  in  4  0=NONE 1=LB 2=LH 3=LW 4=LD 5=LBU 6=LHU 7=LWU 8=SB 9=SH 10=SW 11=SD; 12-15 are treated as NONE
- in_addr  in  64  ALU result; the address for memory ops
- in_wdata  in  64  store data
- in_result  in  64  writeback value for non-memory ops
- in_rdst  in  5  destination register
- stall  out  1  upstream must hold all in_* signals while this is 1
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  bus address (unaligned byte address)
- dreq_size  out  3  0=1B 1=2B 2=4B 3=8B
- dreq_strobe  out  8  byte-write mask; 0 for loads
- dreq_data  out  64  lane-shifted store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  64  raw 8-byte-aligned doubleword
- out_valid  out  1  writeback record valid (one-cycle pulse per accepted input)
- out_rdst  out  5  destination register; 0 for stores and misaligned ops
- out_result  out  64  writeback value
- out_misalign  out  1  accepted access was misaligned

Behaviour:
- Reset value of every output is 0. The FSM resets to IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, in_valid with NONE:
  - Register outputs: out_valid=1, out_result=in_result, out_rdst=in_rdst.
  - Latency is 1 cycle. stall=0.
- IDLE, in_valid with a memory op, aligned:
  - Alignment rule: addr[0]=0 for H, addr[1:0]=0 for W, addr[2:0]=0 for D.
  - Latch op, address, data and rd. Go to REQ.
  - stall=1 combinationally in this cycle.
- IDLE, in_valid with a memory op, misaligned:
  - No bus request is issued.
  - Next cycle: out_valid=1, out_misalign=1, out_result=0, out_rdst=0. stall=0.
- REQ:
  - dreq_valid=1. All dreq_* fields are stable until dresp_addr_ok.
  - On addr_ok, go to WAIT.
  - If addr_ok and data_ok are both high in the same cycle, complete directly.
- WAIT:
  - dreq_valid=0.
  - On data_ok, complete.
- Completion:
  - Next cycle: out_valid=1 and the FSM returns to IDLE.
  - stall is 1 in REQ and WAIT, and drops to 0 in the completing cycle (the cycle data_ok is high). Upstream may therefore present the next instruction in that same cycle. It is not accepted until IDLE.
- Load data path:
  - raw = dresp_data >> (8*addr[2:0]).
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes raw unchanged.
  - out_rdst = latched rd.
- Store data path:
  - dreq_data = wdata << (8*addr[2:0]).
  - dreq_strobe = (0x01, 0x03, 0x0F, 0xFF by size) << addr[2:0].
  - Completion gives out_rdst=0 and out_result=latched in_result.
- out_valid is a single-cycle pulse. It is 0 in every cycle without a completion.
- Responses arriving in IDLE (stray data_ok/addr_ok) are ignored.
- Reset mid-transaction:
  - FSM goes to IDLE; dreq_valid=0 from the next cycle.
  - The pending op is dropped and out_valid is not asserted for it.
- in_valid=0 in IDLE produces no output and no stall.

Test Plan:
- Non-mem op: in_result=0x1234, rd=5 → next cycle out_valid=1, out_result=0x1234, out_rdst=5, stall never asserted.
- LB at addr 0x1003, dresp_data=0x00000000_80000000; addr_ok after 2 cycles, data_ok 3 cycles later:
  - dreq_valid held with size=0 until addr_ok.
  - stall held for the whole transaction.
  - out_result=0xFFFF_FFFF_FFFF_FF80.
- LHU at addr 0x2006, dresp_data=0xBEEF_0000_0000_0000, addr_ok and data_ok in the same cycle → out_result=0x0000_0000_0000_BEEF, total latency 2 cycles.
- SW at addr 0x3004, wdata=0xDEADBEEF → dreq_strobe=0xF0, dreq_data=0xDEADBEEF_00000000, completion with out_rdst=0.
- LW at addr 0x4002 (misaligned) → no dreq_valid, next cycle out_misalign=1, out_valid=1.
- Reset asserted while in WAIT, then a stray data_ok two cycles later → no out_valid, FSM in IDLE, next NONE op accepted normally.
